// File: rtl/ym3438_slot_counter_ring.sv
// ym3438_slot_counter_ring
// A bank of SLOTS independent WIDTH-bit counters. The counters live in a
// two-phase (c1/c2) shift ring, so only one adder is needed. Each counter
// reaches the ring head once every SLOTS c1/c2 pairs and is updated there.
// A slot index tracker reports which counter is currently at the head.
module ym3438_slot_counter_ring #(
  parameter int WIDTH    = 8,
  parameter int SLOTS    = 24,
  parameter bit SATURATE = 1'b0,
  parameter int IDX_W    = 5
) (
  input  logic             MCLK,
  input  logic             rst,
  input  logic             c1,
  input  logic             c2,
  input  logic             en,
  input  logic [WIDTH-1:0] step,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sync,
  output logic [WIDTH-1:0] val,
  output logic [IDX_W-1:0] slot,
  output logic             c_out
);

  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(SLOTS - 1);

  // Stage-1 words are captured on c1 and stage-2 words on c2. The last
  // stage-2 word is the ring head.
  logic [WIDTH-1:0] v1_q [SLOTS];
  logic [WIDTH-1:0] v1_d [SLOTS];
  logic [WIDTH-1:0] v2_q [SLOTS];
  logic [WIDTH-1:0] v2_d [SLOTS];
  logic [IDX_W-1:0] slot_q;
  logic [IDX_W-1:0] slot_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt;

  assign val  = v2_q[SLOTS-1];
  assign slot = slot_q;

  // Compute the head slot's next value. Priority is clr, then load, then count.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sum   = {1'b0, val} + {1'b0, step};
    c_out = en & ~clr & ~load & sum[WIDTH];
    nxt   = val;
    if (clr) begin
      nxt = '0;
    end else if (load) begin
      nxt = load_val;
    end else if (en) begin
      if (SATURATE && sum[WIDTH]) nxt = '1;
      else                        nxt = sum[WIDTH-1:0];
    end
  end

  // Next state of the ring and the slot index. Reset overrides both phases.
  // c1 and c2 on the same edge both use pre-edge values.
  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    slot_d = slot_q;
    if (rst) begin
      // NOTE: the ring storage is cleared word by word on reset because a
      // reset must zero every counter, not just the one at the head.
      for (int i = 0; i < SLOTS; i++) begin
        v1_d[i] = '0;
        v2_d[i] = '0;
      end
      slot_d = '0;
    end else begin
      if (c1) begin
        v1_d[0] = nxt;
        for (int i = 1; i < SLOTS; i++) v1_d[i] = v2_q[i-1];
      end
      if (c2) begin
        v2_d = v1_q;
        if (sync || slot_q == LAST_SLOT) slot_d = '0;
        else                             slot_d = slot_q + 1'b1;
      end
    end
  end

  // Register the ring and the slot index.
  always_ff @(posedge MCLK) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples pre-edge values regardless of statement order.
    v1_q   <= v1_d;
    v2_q   <= v2_d;
    slot_q <= slot_d;
  end

endmodule

// File: tb/tb_ym3438_slot_counter_ring.sv
// Directed bench for ym3438_slot_counter_ring with WIDTH=4, SLOTS=4.
// Two instances share the stimulus: one wraps, one saturates. Expected values
// come from a per-slot counter table kept by the bench and from literals.
module tb_ym3438_slot_counter_ring;

  logic       MCLK = 1'b0;
  logic       rst = 1'b1;
  logic       c1 = 1'b0, c2 = 1'b0, en = 1'b0, clr = 1'b0, load = 1'b0, sync = 1'b0;
  logic [3:0] step = '0, load_val = '0;
  logic [3:0] val_w, val_s;
  logic [4:0] slot_w, slot_s;
  logic       co_w, co_s;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_w [4];
  logic [3:0] exp_s [4];
  int         slot_m = 0;

  always #5 MCLK = ~MCLK;

  ym3438_slot_counter_ring #(.WIDTH(4), .SLOTS(4), .SATURATE(1'b0), .IDX_W(5)) dut_w (
    .MCLK(MCLK), .rst(rst), .c1(c1), .c2(c2), .en(en), .step(step), .clr(clr),
    .load(load), .load_val(load_val), .sync(sync),
    .val(val_w), .slot(slot_w), .c_out(co_w)
  );

  ym3438_slot_counter_ring #(.WIDTH(4), .SLOTS(4), .SATURATE(1'b1), .IDX_W(5)) dut_s (
    .MCLK(MCLK), .rst(rst), .c1(c1), .c2(c2), .en(en), .step(step), .clr(clr),
    .load(load), .load_val(load_val), .sync(sync),
    .val(val_s), .slot(slot_s), .c_out(co_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  // One c1 cycle then one c2 cycle, checking the head before and c_out during c1.
  task automatic do_pair(input logic p_en, input logic [3:0] p_step, input logic p_clr,
                         input logic p_load, input logic [3:0] p_lv, input logic p_sync);
    logic [4:0] sw, ss;
    logic [3:0] tmp_w [4];
    logic [3:0] tmp_s [4];
    check("slot_w", 32'(slot_w), 32'(slot_m));
    check("slot_s", 32'(slot_s), 32'(slot_m));
    check("val_w", 32'(val_w), 32'(exp_w[slot_m]));
    check("val_s", 32'(val_s), 32'(exp_s[slot_m]));
    en = p_en; step = p_step; clr = p_clr; load = p_load; load_val = p_lv; c1 = 1'b1;
    #1;
    sw = {1'b0, exp_w[slot_m]} + {1'b0, p_step};
    ss = {1'b0, exp_s[slot_m]} + {1'b0, p_step};
    check("c_out_w", 32'(co_w), 32'(p_en & ~p_clr & ~p_load & sw[4]));
    check("c_out_s", 32'(co_s), 32'(p_en & ~p_clr & ~p_load & ss[4]));
    tick();
    c1 = 1'b0; c2 = 1'b1; sync = p_sync;
    en = 1'b0; clr = 1'b0; load = 1'b0;
    tick();
    c2 = 1'b0; sync = 1'b0;
    if (p_clr) begin
      exp_w[slot_m] = 4'd0; exp_s[slot_m] = 4'd0;
    end else if (p_load) begin
      exp_w[slot_m] = p_lv; exp_s[slot_m] = p_lv;
    end else if (p_en) begin
      exp_w[slot_m] = sw[3:0];
      exp_s[slot_m] = ss[4] ? 4'hF : ss[3:0];
    end
    if (p_sync) begin
      tmp_w = exp_w; tmp_s = exp_s;
      for (int l = 0; l < 4; l++) begin
        exp_w[l] = tmp_w[(l + slot_m + 1) % 4];
        exp_s[l] = tmp_s[(l + slot_m + 1) % 4];
      end
      slot_m = 0;
    end else begin
      slot_m = (slot_m + 1) % 4;
    end
  endtask

  task automatic idle_pair();
    do_pair(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic advance_to(input int s);
    for (int k = 0; k < 4 && slot_m != s; k++) idle_pair();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin exp_w[i] = 4'd0; exp_s[i] = 4'd0; end

    // Reset state.
    rst = 1'b1; c1 = 1'b1; c2 = 1'b1; sync = 1'b1;
    tick(); tick();
    rst = 1'b0; c1 = 1'b0; c2 = 1'b0; sync = 1'b0;
    check("rst_val", 32'(val_w), 32'd0);
    check("rst_slot", 32'(slot_w), 32'd0);
    check("rst_cout", 32'(co_w), 32'd0);

    // 8 idle pairs: slot cycles 0..3 twice, values stay 0.
    for (int k = 0; k < 8; k++) idle_pair();
    check("t1_slot_wrap", 32'(slot_w), 32'd0);

    // Count only in slot 2 for 20 pairs: five increments of 1.
    for (int k = 0; k < 20; k++) do_pair(slot_m == 2, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0);
    advance_to(2);
    check("t2_slot2_w", 32'(val_w), 32'd5);
    check("t2_slot2_s", 32'(val_s), 32'd5);

    // Load 14 into slot 1, then add 3: wrap to 1, saturate to 15.
    advance_to(1);
    do_pair(1'b0, 4'd0, 1'b0, 1'b1, 4'd14, 1'b0);
    advance_to(1);
    check("t3_loaded_w", 32'(val_w), 32'd14);
    check("t3_loaded_s", 32'(val_s), 32'd14);
    do_pair(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0);
    advance_to(1);
    check("t3_wrap", 32'(val_w), 32'd1);
    check("t3_sat", 32'(val_s), 32'd15);
    do_pair(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0);
    advance_to(1);
    check("t3_wrap2", 32'(val_w), 32'd4);
    check("t3_sat2", 32'(val_s), 32'd15);

    // clr beats load beats en; load does not add step.
    advance_to(3);
    do_pair(1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0);
    advance_to(3);
    do_pair(1'b1, 4'd2, 1'b1, 1'b1, 4'd9, 1'b0);
    advance_to(3);
    check("t4_clr", 32'(val_w), 32'd0);
    do_pair(1'b1, 4'd2, 1'b0, 1'b1, 4'd9, 1'b0);
    advance_to(3);
    check("t4_load", 32'(val_w), 32'd9);

    // Sync on c2 while slot 2 is at the head: slot 3's data becomes label 0.
    advance_to(2);
    do_pair(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    check("t5_sync_slot", 32'(slot_w), 32'd0);
    check("t5_sync_val", 32'(val_w), 32'd9);
    for (int k = 0; k < 5; k++) idle_pair();

    // No c1/c2: state holds while other inputs toggle.
    en = 1'b1; step = 4'd7; load = 1'b1; load_val = 4'd3; clr = 1'b1; sync = 1'b1;
    tick(); tick(); tick();
    en = 1'b0; load = 1'b0; clr = 1'b0; sync = 1'b0;
    idle_pair();

    // Load every slot, then reset between c1 and c2.
    for (int k = 0; k < 4; k++) do_pair(1'b0, 4'd0, 1'b0, 1'b1, 4'(k + 3), 1'b0);
    check("t6_loaded", 32'(val_w), 32'(exp_w[slot_m]));
    c1 = 1'b1; load = 1'b1; load_val = 4'd7;
    tick();
    c1 = 1'b0; load = 1'b0; c2 = 1'b1; rst = 1'b1;
    tick();
    c2 = 1'b0; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin exp_w[i] = 4'd0; exp_s[i] = 4'd0; end
    slot_m = 0;
    check("t6_rst_val", 32'(val_w), 32'd0);
    check("t6_rst_slot", 32'(slot_s), 32'd0);
    for (int k = 0; k < 5; k++) idle_pair();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
